hazard_ctrl: RTL

Pipeline interlock controller for the five-stage MIPS core. It sits beside the ID stage and generates hold and flush signals for PC, IF/ID, ID/EX and EX/MEM. It tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB) and inserts bubbles on read-after-write hazards. It also sequences the multi-cycle multiplier, holding the multiply in EX until its product is valid.

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline interlock controller for the five-stage MIPS core. It sits beside
// ID and tracks in-flight register writes in a 3-entry scoreboard (EX, MEM,
// WB). It stalls the front end on read-after-write hazards and holds a
// multi-cycle multiply in EX until its product is valid.
//
// Parameters
//   MUL_CYCLES : cycles a multiply occupies EX (>= 2)
//   WB_BYPASS  : 1 = write-before-read register file, WB entry never hazards
//   CNT_W      : width of the saturating stall-cycle counter
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_id_valid          : decoded instruction present in ID
//   i_id_rs/i_id_rt     : source register numbers
//   i_id_use_rs/_rt     : instruction reads that source
//   i_id_rd             : destination register
//   i_id_rf_wr          : instruction writes the register file
//   i_id_is_mul         : instruction is a multiply
//   o_stall_front       : hold PC and IF/ID (combinational)
//   o_idex_flush        : load bubble into ID/EX (combinational)
//   o_ex_hold           : hold ID/EX, bubble into EX/MEM (combinational)
//   o_mul_start         : one-cycle multiplier start pulse (registered)
//   o_mul_busy          : FSM is in MUL (registered)
//   o_stall_cnt         : saturating count of stall_front cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter bit          WB_BYPASS  = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_rf_wr,
    input  logic             i_id_is_mul,
    output logic             o_stall_front,
    output logic             o_idex_flush,
    output logic             o_ex_hold,
    output logic             o_mul_start,
    output logic             o_mul_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int unsigned MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_t;

    // FSM and multiply sequencing state
    state_t              r_state;
    logic [MCNT_W-1:0]   r_mcnt;
    logic                r_mul_start;
    logic                r_mul_busy;

    // Scoreboard entries {valid, rd}
    logic                r_ex_v;
    logic [4:0]          r_ex_rd;
    logic                r_mem_v;
    logic [4:0]          r_mem_rd;
    logic                r_wb_v;
    logic [4:0]          r_wb_rd;

    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_rs_hit;
    logic                w_rt_hit;
    logic                w_raw;
    logic                w_issue;
    logic                w_ex_load_v;

    // Source match against valid in-flight destinations; r0 never matches
    assign w_rs_hit = i_id_use_rs && (i_id_rs != 5'd0) &&
                      ((r_ex_v  && (i_id_rs == r_ex_rd))  ||
                       (r_mem_v && (i_id_rs == r_mem_rd)) ||
                       (!WB_BYPASS && r_wb_v && (i_id_rs == r_wb_rd)));

    assign w_rt_hit = i_id_use_rt && (i_id_rt != 5'd0) &&
                      ((r_ex_v  && (i_id_rt == r_ex_rd))  ||
                       (r_mem_v && (i_id_rt == r_mem_rd)) ||
                       (!WB_BYPASS && r_wb_v && (i_id_rt == r_wb_rd)));

    assign w_raw       = i_id_valid && (w_rs_hit || w_rt_hit);
    assign w_issue     = i_id_valid && !w_raw && (r_state == S_RUN);
    assign w_ex_load_v = w_issue && i_id_rf_wr && (i_id_rd != 5'd0);

    // Scoreboard shift; during a multiply EX keeps the multiply's entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_v   <= 1'b0;
            r_ex_rd  <= 5'd0;
            r_mem_v  <= 1'b0;
            r_mem_rd <= 5'd0;
            r_wb_v   <= 1'b0;
            r_wb_rd  <= 5'd0;
        end else if (r_state == S_RUN) begin
            r_ex_v   <= w_ex_load_v;
            r_ex_rd  <= i_id_rd;
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
        end else begin
            r_mem_v  <= 1'b0;
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
        end
    end

    // RUN/MUL sequencer with registered start pulse and busy flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_mcnt      <= MCNT_W'(0);
            r_mul_start <= 1'b0;
            r_mul_busy  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_mul_start <= 1'b0;
            if (w_issue && i_id_is_mul) begin
                r_state     <= S_MUL;
                r_mcnt      <= MCNT_W'(MUL_CYCLES - 1);
                r_mul_start <= 1'b1;
                r_mul_busy  <= 1'b1;
            end
        end else begin
            r_mul_start <= 1'b0;
            // Leave one cycle early so the final EX cycle runs in RUN and
            // EX/MEM captures the product.
            if (r_mcnt <= MCNT_W'(1)) begin
                r_state    <= S_RUN;
                r_mcnt     <= MCNT_W'(0);
                r_mul_busy <= 1'b0;
            end else begin
                r_mcnt <= r_mcnt - MCNT_W'(1);
            end
        end
    end

    // Pipeline control; multiply hold overrides any data hazard
    always_comb begin
        o_stall_front = 1'b0;
        o_idex_flush  = 1'b0;
        o_ex_hold     = 1'b0;
        if (!i_rst) begin
            if (r_state == S_RUN) begin
                o_stall_front = w_raw;
                o_idex_flush  = w_raw;
            end else if (r_mcnt != MCNT_W'(0)) begin
                o_stall_front = 1'b1;
                o_ex_hold     = 1'b1;
            end
        end
    end

    // Saturating count of front-end stall cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= CNT_W'(0);
        end else if (o_stall_front && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_mul_start = r_mul_start;
    assign o_mul_busy  = r_mul_busy;
    assign o_stall_cnt = r_stall_cnt;

endmodule
